// File: rtl/lifo_buffer_if.sv
//------------------------------------------------------------------------------
// Module   : lifo_buffer_if
// Purpose  : Operation and status bundle between a LIFO user and lifo_buffer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface lifo_buffer_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  push_i;
  logic                  pop_i;
  logic                  flush_i;
  logic                  clear_err_i;
  logic [DATA_WIDTH-1:0] write_data_i;
  logic [DATA_WIDTH-1:0] top_o;
  logic [ADDR_WIDTH:0]   count_o;
  logic                  empty_o;
  logic                  full_o;
  logic                  almost_full_o;
  logic                  overflow_o;
  logic                  underflow_o;

  modport master (
    output push_i, pop_i, flush_i, clear_err_i, write_data_i,
    input  top_o, count_o, empty_o, full_o, almost_full_o, overflow_o, underflow_o
  );

  modport slave (
    input  push_i, pop_i, flush_i, clear_err_i, write_data_i,
    output top_o, count_o, empty_o, full_o, almost_full_o, overflow_o, underflow_o
  );
endinterface

`default_nettype wire

// File: rtl/lifo_buffer.sv
//------------------------------------------------------------------------------
// Module   : lifo_buffer
// Purpose  : Parametrised LIFO stack with replace-top, flush, almost-full and
//            sticky overflow/underflow flags.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lifo_buffer #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int AF_THRESH  = 2**ADDR_WIDTH - 2
) (
  input  wire logic        clk_i,
  input  wire logic        reset_i,
  lifo_buffer_if.slave     lifo
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  localparam logic [CW-1:0] C_ONE      = CW'(1);
  localparam logic [CW-1:0] C_FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF_LVL   = CW'(AF_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic                  empty;
  logic                  full;
  logic                  push_op;
  logic                  pop_op;
  logic                  repl_op;
  logic                  ovf_set;
  logic                  unf_set;
  logic [ADDR_WIDTH-1:0] top_idx;
  logic [ADDR_WIDTH-1:0] wr_idx;

  assign empty = (count_q == '0);
  assign full  = (count_q == C_FULL_LVL);

  // Push+pop on an empty stack degenerates to a plain push.
  assign push_op = ~lifo.flush_i & lifo.push_i & (~lifo.pop_i | empty) & ~full;
  assign pop_op  = ~lifo.flush_i & lifo.pop_i & ~lifo.push_i & ~empty;
  assign repl_op = ~lifo.flush_i & lifo.push_i & lifo.pop_i & ~empty;
  assign ovf_set = ~lifo.flush_i & lifo.push_i & ~lifo.pop_i & full;
  assign unf_set = ~lifo.flush_i & lifo.pop_i & ~lifo.push_i & empty;

  // Low bits of count-1 wrap to DEPTH-1 when full, which is the correct top.
  assign top_idx = count_q[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
  assign wr_idx  = repl_op ? top_idx : count_q[ADDR_WIDTH-1:0];

  always_comb begin
    count_d = count_q;
    if (lifo.flush_i) begin
      count_d = '0;
    end else if (push_op) begin
      count_d = count_q + C_ONE;
    end else if (pop_op) begin
      count_d = count_q - C_ONE;
    end
  end

  assign ovf_d = ovf_set | (ovf_q & ~lifo.clear_err_i);
  assign unf_d = unf_set | (unf_q & ~lifo.clear_err_i);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_op | repl_op) begin
      mem_q[wr_idx] <= lifo.write_data_i;
    end
  end

  assign lifo.top_o         = empty ? '0 : mem_q[top_idx];
  assign lifo.count_o       = count_q;
  assign lifo.empty_o       = empty;
  assign lifo.full_o        = full;
  assign lifo.almost_full_o = (count_q >= C_AF_LVL);
  assign lifo.overflow_o    = ovf_q;
  assign lifo.underflow_o   = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_lifo_buffer.sv
//------------------------------------------------------------------------------
// Module   : tb_lifo_buffer
// Purpose  : Scoreboard bench for lifo_buffer (ADDR_WIDTH=2, DATA_WIDTH=8).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_lifo_buffer;

  localparam int AW  = 2;
  localparam int DW  = 8;
  localparam int DEP = 4;
  localparam int AFT = 2;

  typedef struct {
    int       count;
    int       top;
    bit       empty;
    bit       full;
    bit       af;
    bit       ovf;
    bit       unf;
    string    tag;
  } exp_t;

  logic clk;
  logic rst;

  int checks;
  int failures;

  logic [DW-1:0] stk[$];
  bit            m_ovf;
  bit            m_unf;
  exp_t          sb[$];

  lifo_buffer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  lifo_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AF_THRESH(AFT)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .lifo    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_op(input bit push, input bit pop, input bit flush,
                          input bit clr, input logic [DW-1:0] d);
    bit os;
    bit us;
    os = 1'b0;
    us = 1'b0;
    if (flush) begin
      stk.delete();
    end else if (push && !pop) begin
      if (stk.size() == DEP) os = 1'b1;
      else stk.push_back(d);
    end else if (pop && !push) begin
      if (stk.size() == 0) us = 1'b1;
      else void'(stk.pop_back());
    end else if (push && pop) begin
      if (stk.size() == 0) stk.push_back(d);
      else stk[stk.size()-1] = d;
    end
    m_ovf = os | (m_ovf & ~clr);
    m_unf = us | (m_unf & ~clr);
  endtask

  function automatic exp_t snapshot(input string tag);
    exp_t e;
    e.count = stk.size();
    e.top   = (stk.size() == 0) ? 0 : int'(stk[stk.size()-1]);
    e.empty = (stk.size() == 0);
    e.full  = (stk.size() == DEP);
    e.af    = (stk.size() >= AFT);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    e.tag   = tag;
    return e;
  endfunction

  task automatic compare_head();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check({e.tag, ".count"}, 32'(bus.count_o),       32'(e.count));
    check({e.tag, ".top"},   32'(bus.top_o),         32'(e.top));
    check({e.tag, ".empty"}, 32'(bus.empty_o),       32'(e.empty));
    check({e.tag, ".full"},  32'(bus.full_o),        32'(e.full));
    check({e.tag, ".af"},    32'(bus.almost_full_o), 32'(e.af));
    check({e.tag, ".ovf"},   32'(bus.overflow_o),    32'(e.ovf));
    check({e.tag, ".unf"},   32'(bus.underflow_o),   32'(e.unf));
  endtask

  task automatic step(input string tag, input bit push, input bit pop, input bit flush,
                      input bit clr, input logic [DW-1:0] d);
    @(negedge clk);
    bus.push_i       = push;
    bus.pop_i        = pop;
    bus.flush_i      = flush;
    bus.clear_err_i  = clr;
    bus.write_data_i = d;
    model_op(push, pop, flush, clr, d);
    sb.push_back(snapshot(tag));
    @(posedge clk);
    #1;
    compare_head();
    bus.push_i      = 1'b0;
    bus.pop_i       = 1'b0;
    bus.flush_i     = 1'b0;
    bus.clear_err_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".count"}, 32'(bus.count_o),       32'd0);
    check({tag, ".top"},   32'(bus.top_o),         32'd0);
    check({tag, ".empty"}, 32'(bus.empty_o),       32'd1);
    check({tag, ".full"},  32'(bus.full_o),        32'd0);
    check({tag, ".af"},    32'(bus.almost_full_o), 32'd0);
    check({tag, ".ovf"},   32'(bus.overflow_o),    32'd0);
    check({tag, ".unf"},   32'(bus.underflow_o),   32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    rst              = 1'b1;
    bus.push_i       = 1'b0;
    bus.pop_i        = 1'b0;
    bus.flush_i      = 1'b0;
    bus.clear_err_i  = 1'b0;
    bus.write_data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    step("push11", 1, 0, 0, 0, 8'h11);
    check("af_at1", 32'(bus.almost_full_o), 32'd0);
    step("push22", 1, 0, 0, 0, 8'h22);
    check("af_at2", 32'(bus.almost_full_o), 32'd1);
    step("push33", 1, 0, 0, 0, 8'h33);
    step("push44", 1, 0, 0, 0, 8'h44);
    check("full_top", 32'(bus.top_o), 32'h44);
    check("full_flag", 32'(bus.full_o), 32'd1);

    step("ovf55", 1, 0, 0, 0, 8'h55);
    check("ovf_set", 32'(bus.overflow_o), 32'd1);
    step("repl66", 1, 1, 0, 0, 8'h66);
    check("repl_top", 32'(bus.top_o), 32'h66);

    step("pop1", 0, 1, 0, 0, 8'h00);
    check("pop1_top", 32'(bus.top_o), 32'h33);
    step("pop2", 0, 1, 0, 0, 8'h00);
    step("pop3", 0, 1, 0, 0, 8'h00);
    step("pop4", 0, 1, 0, 0, 8'h00);
    step("pop5", 0, 1, 0, 0, 8'h00);
    check("unf_set", 32'(bus.underflow_o), 32'd1);

    step("clr", 0, 0, 0, 1, 8'h00);
    check("clr_ovf", 32'(bus.overflow_o), 32'd0);
    step("clr_vs_unf", 0, 1, 0, 1, 8'h00);
    check("set_wins", 32'(bus.underflow_o), 32'd1);
    step("clr2", 0, 0, 0, 1, 8'h00);

    step("pp_empty77", 1, 1, 0, 0, 8'h77);
    check("pp_empty_top", 32'(bus.top_o), 32'h77);
    step("flush_push", 1, 0, 1, 0, 8'h99);
    check("flush_empty", 32'(bus.empty_o), 32'd1);

    for (int i = 0; i < 60; i++) begin
      logic [3:0] r;
      r = 4'($urandom_range(0, 15));
      step($sformatf("rnd%0d", i), r[0] | r[3], r[1], (r == 4'hF), r[2] & r[1],
           8'($urandom));
    end

    step("flush2", 0, 0, 1, 1, 8'h00);
    step("pushAA", 1, 0, 0, 0, 8'hAA);
    step("pushBB", 1, 0, 0, 0, 8'hBB);
    check("pre_rst_top", 32'(bus.top_o), 32'hBB);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step("pushCC", 1, 0, 0, 0, 8'hCC);
    check("post_rst_top", 32'(bus.top_o), 32'hCC);
    step("popCC", 0, 1, 0, 0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lifo_buffer.md
# lifo_buffer

Parametrised LIFO stack that supersedes the fixed 4-bit stack. It adds a depth counter, a combinational top-of-stack read, same-cycle push+pop (replace top), synchronous flush, an almost-full threshold and sticky overflow/underflow error flags. It sits between a producer/consumer pair that need last-in-first-out buffering with explicit error reporting, and is built on the team's register-file storage.

## Interface
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH entries
- DATA_WIDTH, 8, entry width in bits
- AF_THRESH, 2**ADDR_WIDTH-2, almost_full_o asserts when count >= AF_THRESH (legal range 1..DEPTH)

- clk_i  input  1  single clock, all state updates on rising edge
- reset_i  input  1  asynchronous, active-high reset
- push_i  input  1  push write_data_i this cycle
- pop_i  input  1  pop top entry this cycle
- flush_i  input  1  synchronous empty; highest priority
- clear_err_i  input  1  synchronous clear of sticky error flags
- write_data_i  input  DATA_WIDTH  data to push or replace top with
- top_o  output  DATA_WIDTH  current top entry, 0 when empty
- count_o  output  ADDR_WIDTH+1  number of valid entries, 0..DEPTH
- empty_o  output  1  count_o == 0
- full_o  output  1  count_o == DEPTH
- almost_full_o  output  1  count_o >= AF_THRESH
- overflow_o  output  1  sticky: push attempted while full without pop
- underflow_o  output  1  sticky: pop attempted while empty without push

## Operation
- Storage: DEPTH x DATA_WIDTH array, not reset; entry i valid for i < count. Top entry is index count-1.
- Per-cycle priority, evaluated on rising edge:
  - flush_i=1: count <- 0; push/pop ignored; no error flags set.
  - push & ~pop: if !full, mem[count] <- data, count+1; if full, ignored, overflow set.
  - pop & ~push: if !empty, count-1 (data discarded); if empty, ignored, underflow set.
  - push & pop, !empty: replace, mem[count-1] <- data, count unchanged (legal when full).
  - push & pop, empty: treated as plain push, count 0->1, no underflow.
  - neither: hold.
- top_o = mem[count-1] read combinationally from current state; forced to 0 when empty.
- Status outputs are combinational decodes of the registered count.
- Error flags: set by the conditions above and held until clear_err_i. If clear_err_i coincides with a new error, the flag remains set (set wins).
- Count arithmetic uses ADDR_WIDTH+1 bits. Never wraps: increments are blocked at DEPTH and decrements at 0.

## Timing
- Reset (asynchronous, immediate): count_o=0, empty_o=1, full_o=0, almost_full_o=0, overflow_o=0, underflow_o=0, top_o=0. Memory contents are undefined but unreachable.
- Reset asserted mid-operation discards all entries at once. First push after deassertion writes index 0.
- Latency: push/pop/replace/flush effects appear on count_o, flags and top_o immediately after the active edge (1 cycle from input sample). A push is visible on top_o the cycle after it is sampled.
- No handshake stall: the block accepts one operation every cycle. Illegal requests are dropped and flagged, never queued.
- Back-to-back push then pop returns the pushed data on top_o in the pop cycle, before the edge. Alternating push/pop therefore sustains full throughput.

## Test plan
- Reset, then ADDR_WIDTH=2, DATA_WIDTH=8. Push 0x11, 0x22, 0x33, 0x44 -> count_o 1,2,3,4; top_o 0x44; full_o=1; almost_full_o=1 from count 2 (AF_THRESH=2).
- From full, push 0x55 alone -> count stays 4, top_o 0x44, overflow_o=1. Then push+pop with 0x66 -> top_o 0x66, count 4, no new error.
- Pop four times -> top_o sequence 0x66, 0x33, 0x22, 0x11, then 0 with empty_o=1. A fifth pop sets underflow_o=1 and count stays 0.
- With both error flags set, assert clear_err_i alone -> both clear next cycle. Assert clear_err_i with a pop on empty -> underflow_o stays 1.
- Push+pop while empty with 0x77 -> count 1, top_o 0x77, underflow_o=0. Then flush_i with push_i=1 -> count 0, empty_o=1, no error.
- Push 0xAA, 0xBB, then assert reset_i asynchronously mid-cycle -> outputs go to reset values before the next edge. First push after release, 0xCC -> count 1, top_o 0xCC.
